// File: rtl/gc_controller_poller.sv
// rtl/gc_controller_poller.sv - GameCube controller poller producing the packed controller_in word
//
// Purpose:
//   Periodically sends the 0x400300 poll command on the single-wire open-drain
//   bus, receives the 64-bit status frame, validates it and publishes a packed
//   32-bit controller word with a one-cycle strobe. Timeouts and malformed
//   frames publish a neutral-stick word and clear `connected`.
//
// Ports:
//   clock          - master clock
//   reset          - asynchronous active-low reset
//   data_in        - raw bus level (asynchronous, synchronized internally)
//   data_oe        - 1 pulls the bus low through the top-level tristate
//   controller_out - packed word {0,Start,R,L,Z,B,A,X|Y, 8'h00, stickX, stickY}
//   valid          - one-cycle strobe on every controller_out update
//   connected      - 1 while the most recent transaction passed
module gc_controller_poller #(
  parameter int unsigned CLKS_PER_US    = 50,
  parameter int unsigned POLL_PERIOD_US = 1000,
  parameter int unsigned TIMEOUT_US     = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_in,
  output logic        data_oe,
  output logic [31:0] controller_out,
  output logic        valid,
  output logic        connected
);

  localparam int unsigned BIT_CYC  = 4 * CLKS_PER_US;
  localparam int unsigned TO_CYC   = TIMEOUT_US * CLKS_PER_US;
  localparam int unsigned POLL_CYC = POLL_PERIOD_US * CLKS_PER_US;
  localparam int unsigned CNT_MAX  = (BIT_CYC > TO_CYC) ? BIT_CYC : TO_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned POLL_W   = $clog2(POLL_CYC + 1);

  localparam logic [CNT_W-1:0]  LOW_ONE   = CNT_W'(CLKS_PER_US);
  localparam logic [CNT_W-1:0]  LOW_ZERO  = CNT_W'(3 * CLKS_PER_US);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  US_LAST   = CNT_W'(CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_AT = CNT_W'(2 * CLKS_PER_US);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TO_CYC - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYC - 1);

  localparam logic [31:0] NEUTRAL = 32'h0000_8080;
  localparam logic [23:0] CMD     = 24'h40_0300;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_BIT,
    S_TX_STOP,
    S_RX_WAIT,
    S_RX_SAMPLE,
    S_CHECK,
    S_UPDATE,
    S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [6:0]          bit_cnt_q, bit_cnt_d;
  logic [23:0]         tx_sr_q, tx_sr_d;
  logic [63:0]         rx_q, rx_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic                poll_pend_q, poll_pend_d;
  logic [31:0]         out_q, out_d;
  logic                valid_q, valid_d;
  logic                conn_q, conn_d;
  logic [2:0]          sync_q, sync_d;

  logic        line;
  logic        fall;
  logic        poll_hit;
  logic        go_fail;
  logic        frame_ok;
  logic [31:0] rx_word;
  logic        unused_rx;

  // sync_q[1] is the two-flop synchronized level; sync_q[2] is its previous value.
  assign sync_d = {sync_q[1:0], data_in};
  assign line   = sync_q[1];
  assign fall   = sync_q[2] & ~sync_q[1];

  assign frame_ok = (rx_q[63:61] == 3'b000) && rx_q[55];
  assign rx_word  = {1'b0, rx_q[60], rx_q[53], rx_q[54], rx_q[52], rx_q[57], rx_q[56],
                     rx_q[58] | rx_q[59], 8'h00, rx_q[47:40], rx_q[39:32]};

  // Frame bits with no place in the packed word (D-pad, C-stick, analog triggers).
  assign unused_rx = ^{rx_q[51:48], rx_q[31:0]};

  assign controller_out = out_q;
  assign valid          = valid_q;
  assign connected      = conn_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_q        <= '0;
      poll_cnt_q  <= '0;
      poll_pend_q <= 1'b0;
      out_q       <= NEUTRAL;
      valid_q     <= 1'b0;
      conn_q      <= 1'b0;
      sync_q      <= 3'b111;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_q        <= rx_d;
      poll_cnt_q  <= poll_cnt_d;
      poll_pend_q <= poll_pend_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      conn_q      <= conn_d;
      sync_q      <= sync_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_d      = rx_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    conn_d    = conn_q;
    data_oe   = 1'b0;
    go_fail   = 1'b0;

    // Poll timer runs free; an expiry during a transaction is remembered
    // and serviced as soon as IDLE is reached.
    poll_hit    = (poll_cnt_q == POLL_LAST);
    poll_cnt_d  = poll_hit ? '0 : poll_cnt_q + 1'b1;
    poll_pend_d = poll_pend_q | poll_hit;

    case (state_q)
      S_IDLE: begin
        if (poll_pend_q || poll_hit) begin
          state_d     = S_TX_BIT;
          poll_cnt_d  = '0;
          poll_pend_d = 1'b0;
          cnt_d       = '0;
          bit_cnt_d   = '0;
          tx_sr_d     = CMD;
        end
      end

      S_TX_BIT: begin
        // Low phase first: 1 us for a one, 3 us for a zero, within a 4 us slot.
        data_oe = (cnt_q < (tx_sr_q[23] ? LOW_ONE : LOW_ZERO));
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          tx_sr_d = {tx_sr_q[22:0], 1'b0};
          if (bit_cnt_q == 7'd23) begin
            bit_cnt_d = '0;
            state_d   = S_TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_TX_STOP: begin
        data_oe = 1'b1;
        if (cnt_q == US_LAST) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_RX_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RX_WAIT: begin
        if (fall) begin
          cnt_d = '0;
          if (bit_cnt_q == 7'd64) begin
            state_d = S_CHECK;
          end else begin
            // The edge cycle itself counts as the first cycle of the bit.
            state_d = S_RX_SAMPLE;
            cnt_d   = CNT_W'(1);
          end
        end else if (cnt_q == TO_LAST) begin
          go_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RX_SAMPLE: begin
        if (cnt_q == SAMPLE_AT) begin
          rx_d      = {rx_q[62:0], line};
          bit_cnt_d = bit_cnt_q + 7'd1;
          cnt_d     = '0;
          state_d   = S_RX_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CHECK: begin
        if (frame_ok) begin
          out_d   = rx_word;
          valid_d = 1'b1;
          conn_d  = 1'b1;
          state_d = S_UPDATE;
        end else begin
          go_fail = 1'b1;
        end
      end

      S_UPDATE: state_d = S_IDLE;

      S_FAIL: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Outputs change on the FAIL entry edge, together with the strobe.
    if (go_fail) begin
      state_d = S_FAIL;
      cnt_d   = '0;
      out_d   = NEUTRAL;
      valid_d = 1'b1;
      conn_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_gc_controller_poller.sv
// tb/tb_gc_controller_poller.sv - scoreboard bench for gc_controller_poller
`timescale 1ns/1ps
module tb_gc_controller_poller;

  localparam int CPU      = 4;
  localparam int PERIOD   = 600;
  localparam int TO       = 20;
  localparam int POLL_CYC = CPU * PERIOD;
  localparam int TO_CYC   = CPU * TO;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dev_low = 1'b0;
  logic        data_in;
  logic        data_oe;
  logic [31:0] controller_out;
  logic        valid;
  logic        connected;

  // Open-drain bus: low if either side pulls.
  assign data_in = ~(data_oe | dev_low);

  always #5 clock = ~clock;

  gc_controller_poller #(
    .CLKS_PER_US   (CPU),
    .POLL_PERIOD_US(PERIOD),
    .TIMEOUT_US    (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_in       (data_in),
    .data_oe       (data_oe),
    .controller_out(controller_out),
    .valid         (valid),
    .connected     (connected)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int prev_start = 0;
  int spurious = 0;
  logic [32:0] exp_q[$];

  always @(posedge clock) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid strobe pops one expected {connected, word}.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clock);
      if (reset && valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid actual=%0h expected=none", controller_out);
        end else begin
          e = exp_q.pop_front();
          check("sb_word", {31'd0, connected, controller_out}, {31'd0, e});
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    if (data_oe) spurious++;
  endtask

  function automatic logic [63:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] sx, input logic [7:0] sy);
    return {b0, b1, sx, sy, 32'h8080_0000};
  endfunction

  task automatic do_txn(input string name, input logic [63:0] resp, input int nbits,
                        input logic [31:0] exp_word, input logic exp_conn);
    int n;
    int w;
    int g;
    int oe_fall;
    int vc0;
    logic [23:0] cmd;
    n = 0;
    while (!data_oe && n < POLL_CYC + 100) begin
      @(negedge clock);
      n++;
    end
    if (!data_oe) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s start_timeout actual=none expected=data_oe", name);
      return;
    end
    check({name, "_poll_period"}, cyc - prev_start, POLL_CYC);
    prev_start = cyc;
    cmd = '0;
    for (int i = 0; i < 25; i++) begin
      w = 0;
      while (data_oe && w < 100) begin
        @(negedge clock);
        w++;
      end
      if (i < 24) begin
        g = 0;
        while (!data_oe && g < 100) begin
          @(negedge clock);
          g++;
        end
        check({name, "_cmd_bit_shape"}, ((w == 12 && g == 4) || (w == 4 && g == 12)), 1);
        cmd = {cmd[22:0], (w == 4)};
      end else begin
        check({name, "_stop_width"}, w, 4);
      end
    end
    oe_fall = cyc;
    check({name, "_cmd"}, cmd, 24'h40_0300);

    exp_q.push_back({exp_conn, exp_word});
    vc0 = valid_cnt;
    spurious = 0;
    repeat (8) tick();
    for (int i = 0; i < nbits; i++) begin
      dev_low = 1'b1;
      repeat (resp[63-i] ? 4 : 12) tick();
      dev_low = 1'b0;
      repeat (resp[63-i] ? 12 : 4) tick();
    end
    if (nbits == 64) begin
      dev_low = 1'b1;
      repeat (4) tick();
      dev_low = 1'b0;
    end
    n = 0;
    while (valid_cnt == vc0 && n < 300) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check({name, "_valid_pulses"}, valid_cnt - vc0, 1);
    check({name, "_no_oe_rx"}, spurious, 0);
    if (nbits == 0) check({name, "_timeout_latency"}, last_valid_cyc - oe_fall, TO_CYC);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_data_oe", data_oe, 0);
    check("rst_out", controller_out, 32'h0000_8080);
    check("rst_valid", valid, 0);
    check("rst_conn", connected, 0);
    reset = 1'b1;

    n = 0;
    while (!data_oe && n < POLL_CYC + 100) begin
      @(negedge clock);
      n++;
    end
    check("first_poll_cyc", cyc, POLL_CYC);
    repeat (2) @(negedge clock);
    check("pre_reset_oe", data_oe, 1);
    #1 reset = 1'b0;
    #1 check("async_oe_release", data_oe, 0);
    repeat (3) @(negedge clock);
    check("mid_rst_out", controller_out, 32'h0000_8080);
    check("mid_rst_conn", connected, 0);
    check("mid_rst_valid", valid, 0);
    reset = 1'b1;
    prev_start = 0;

    do_txn("good",     mk(8'h09, 8'h80, 8'hC0, 8'h20), 64, 32'h0300_C020, 1'b1);
    do_txn("none",     64'd0,                          0,  32'h0000_8080, 1'b0);
    do_txn("bad_b1",   mk(8'h09, 8'h00, 8'hC0, 8'h20), 64, 32'h0000_8080, 1'b0);
    do_txn("good2",    mk(8'h12, 8'hD0, 8'h7F, 8'h81), 64, 32'h5C00_7F81, 1'b1);
    do_txn("trunc40",  mk(8'h09, 8'h80, 8'hC0, 8'h20), 40, 32'h0000_8080, 1'b0);
    do_txn("bad_hi",   mk(8'h21, 8'h80, 8'hC0, 8'h20), 64, 32'h0000_8080, 1'b0);
    do_txn("good3",    mk(8'h04, 8'hA0, 8'h00, 8'hFF), 64, 32'h2100_00FF, 1'b1);

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
